// File: rtl/partial_load_unit_pkg.sv
// partial_load_unit shared types:
// load funct3 codes, FSM states, decode helpers
package partial_load_unit_pkg;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT0 = 2'd1,
    S_WAIT1 = 2'd2,
    S_RESP  = 2'd3
  } plu_state_e;

  function automatic logic fnc_legal(
    input logic [2:0] f
  );
    logic ok;
    case (f)
      FNC_LB, FNC_LH, FNC_LW,
      FNC_LBU, FNC_LHU: ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Access crosses into the next word
  function automatic logic fnc_spans(
    input logic [2:0] f,
    input logic [1:0] off
  );
    logic sp;
    case (f)
      FNC_LW:          sp = (off != 2'd0);
      FNC_LH, FNC_LHU: sp = (off == 2'd3);
      default:         sp = 1'b0;
    endcase
    return sp;
  endfunction

endpackage

// File: rtl/partial_load_unit_if.sv
// partial_load_unit bus: request, memory
// read port and response, one bundle
interface partial_load_unit_if #(
  parameter int ADDR_W = 14
) ();
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_funct3, req_addr,
    output mem_rdata, resp_ready,
    input  req_ready, mem_en, mem_addr,
    input  resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_funct3, req_addr,
    input  mem_rdata, resp_ready,
    output req_ready, mem_en, mem_addr,
    output resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/partial_load_unit_extract.sv
// load_extract: shift a 64-bit window by the byte
// offset and sign/zero extend per funct3
module load_extract
  import partial_load_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [63:0] win_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);
  logic [31:0] sh;

  assign sh = 32'(win_i >> {off_i, 3'b000});

  // Extend the selected lanes of the shifted window
  always_comb begin
    data_o = '0;
    case (funct3_i)
      FNC_LB:  data_o = {{24{sh[7]}}, sh[7:0]};
      FNC_LBU: data_o = {24'b0, sh[7:0]};
      FNC_LH:  data_o = {{16{sh[15]}}, sh[15:0]};
      FNC_LHU: data_o = {16'b0, sh[15:0]};
      FNC_LW:  data_o = sh;
      default: data_o = '0;
    endcase
  end
endmodule

// File: rtl/partial_load_unit.sv
// partial_load_unit: byte/half/word loads from a
// sync-read memory, two reads for spanning accesses
module partial_load_unit
  import partial_load_unit_pkg::*;
#(
  parameter int ADDR_W             = 14,
  parameter bit SUPPORT_MISALIGNED = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  partial_load_unit_if.slave bus
);
  plu_state_e        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              span_q, span_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       low_q, low_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] req_waddr;
  logic              req_span;
  logic              req_go;
  logic [63:0]       win;
  logic [31:0]       ext;
  logic              unused_addr;

  assign req_waddr   = bus.req_addr[ADDR_W+1:2];
  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];
  assign req_span    = fnc_spans(bus.req_funct3,
                                 bus.req_addr[1:0]);
  assign req_go      = fnc_legal(bus.req_funct3) &&
                       (!req_span || SUPPORT_MISALIGNED);

  assign win = (state_q == S_WAIT1) ?
               {bus.mem_rdata, low_q} :
               {32'b0, bus.mem_rdata};

  load_extract u_ext (
    .funct3_i (f3_q),
    .win_i    (win),
    .off_i    (off_q),
    .data_o   (ext)
  );

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;

  // Next state, memory read strobe and result capture
  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    off_d        = off_q;
    span_d       = span_q;
    waddr_d      = waddr_q;
    low_d        = low_q;
    data_d       = data_q;
    err_d        = err_q;
    bus.mem_en   = 1'b0;
    bus.mem_addr = req_waddr;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (req_go) begin
            bus.mem_en = 1'b1;
            f3_d       = bus.req_funct3;
            off_d      = bus.req_addr[1:0];
            span_d     = req_span;
            waddr_d    = req_waddr;
            state_d    = S_WAIT0;
          end else begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_WAIT0: begin
        if (span_q) begin
          low_d        = bus.mem_rdata;
          bus.mem_en   = 1'b1;
          bus.mem_addr = waddr_q + 1'b1;
          state_d      = S_WAIT1;
        end else begin
          data_d  = ext;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_WAIT1: begin
        data_d  = ext;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      off_q   <= '0;
      span_q  <= 1'b0;
      waddr_q <= '0;
      low_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      span_q  <= span_d;
      waddr_q <= waddr_d;
      low_q   <= low_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_partial_load_unit.sv
// tb_partial_load_unit: directed loads into two units
// (misaligned on/off), queued expectations, monitor
module tb_partial_load_unit;
  import partial_load_unit_pkg::*;

  localparam int AW = 14;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    int          hold;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  partial_load_unit_if #(.ADDR_W(AW)) if1 ();
  partial_load_unit_if #(.ADDR_W(AW)) if0 ();

  partial_load_unit #(
    .ADDR_W(AW), .SUPPORT_MISALIGNED(1'b1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  partial_load_unit #(
    .ADDR_W(AW), .SUPPORT_MISALIGNED(1'b0)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  logic [31:0] mem [0:(1<<AW)-1];
  int cyc = 0;
  int en1 = 0;
  int en0 = 0;
  int a1q[$];
  exp_t q1[$];
  exp_t q0[$];
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (if1.mem_en) begin
      if1.mem_rdata <= mem[if1.mem_addr];
      en1 <= en1 + 1;
      a1q.push_back(int'(if1.mem_addr));
    end
    if (if0.mem_en) begin
      if0.mem_rdata <= mem[if0.mem_addr];
      en0 <= en0 + 1;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [31:0] d, logic e,
                              int lat, int h);
    exp_t r;
    r.data = d;
    r.err  = e;
    r.cyc  = lat;
    r.hold = h;
    return r;
  endfunction

  task automatic issue(input logic [2:0] f,
                       input logic [31:0] a,
                       input exp_t e1, input exp_t e0);
    int n = 0;
    @(negedge clk);
    while (!(if1.req_ready && if0.req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait",
        {31'b0, if1.req_ready && if0.req_ready}, 32'd1);
    if1.req_valid = 1'b1;  if0.req_valid = 1'b1;
    if1.req_funct3 = f;    if0.req_funct3 = f;
    if1.req_addr = a;      if0.req_addr = a;
    e1.cyc += cyc;
    e0.cyc += cyc;
    q1.push_back(e1);
    q0.push_back(e0);
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0;
    if0.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q0.size() != 0 ||
            !if1.req_ready || !if0.req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got q1=%0d q0=%0d want 0",
               q1.size(), q0.size());
      q1.delete();
      q0.delete();
    end
  endtask

  task automatic mon(input int id, input logic v,
                     input logic [31:0] d, input logic e,
                     input logic rq,
                     inout logic seen, inout int hc,
                     inout exp_t cur, output logic rdy);
    rdy = 1'b0;
    if (!v) begin
      seen = 1'b0;
      return;
    end
    if (!seen) begin
      seen = 1'b1;
      hc = 0;
      if ((id == 1 ? q1.size() : q0.size()) == 0) begin
        tests++;
        fails++;
        $display("FAIL dut%0d unexpected_resp: got %h want none",
                 id, d);
        cur = mk(d, e, cyc, 0);
      end else begin
        if (id == 1) cur = q1.pop_front();
        else         cur = q0.pop_front();
        chk($sformatf("dut%0d resp_data", id), d, cur.data);
        chk($sformatf("dut%0d resp_err", id),
            {31'b0, e}, {31'b0, cur.err});
        chk($sformatf("dut%0d resp_cycle", id),
            cyc, cur.cyc);
        hc = cur.hold;
      end
    end else begin
      chk($sformatf("dut%0d hold_data", id), d, cur.data);
      chk($sformatf("dut%0d hold_err", id),
          {31'b0, e}, {31'b0, cur.err});
      chk($sformatf("dut%0d hold_req_ready", id),
          {31'b0, rq}, 32'd0);
    end
    if (hc > 0) hc--;
    else        rdy = 1'b1;
  endtask

  logic seen1 = 1'b0;
  logic seen0 = 1'b0;
  int   hc1 = 0;
  int   hc0 = 0;
  exp_t cur1, cur0;

  initial begin
    logic r;
    if1.resp_ready = 1'b0;
    if0.resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mon(1, if1.resp_valid, if1.resp_data, if1.resp_err,
            if1.req_ready, seen1, hc1, cur1, r);
        if1.resp_ready = r;
        mon(0, if0.resp_valid, if0.resp_data, if0.resp_err,
            if0.req_ready, seen0, hc0, cur0, r);
        if0.resp_ready = r;
      end else begin
        seen1 = 1'b0;
        seen0 = 1'b0;
        if1.resp_ready = 1'b0;
        if0.resp_ready = 1'b0;
      end
    end
  end

  initial begin
    int b1, b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    if1.req_valid = 1'b0;  if0.req_valid = 1'b0;
    if1.req_funct3 = '0;   if0.req_funct3 = '0;
    if1.req_addr = '0;     if0.req_addr = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst resp_valid", {31'b0, if1.resp_valid}, 32'd0);
    chk("rst resp_data", if1.resp_data, 32'd0);
    chk("rst resp_err", {31'b0, if1.resp_err}, 32'd0);
    chk("rst mem_en", {31'b0, if1.mem_en}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst req_ready", {31'b0, if1.req_ready}, 32'd1);

    // LB sign-extended, one read of word 0
    mem[0] = 32'h80FF_1234;
    a1q.delete();
    b1 = en1;
    issue(FNC_LB, 32'h3, mk(32'hFFFF_FF80, 0, 2, 0),
          mk(32'hFFFF_FF80, 0, 2, 0));
    drain();
    chk("lb mem_en_count", en1 - b1, 32'd1);
    chk("lb mem_addr", (a1q.size() > 0) ? a1q[0] : -1, 32'd0);
    chk("idle resp_data_kept", if1.resp_data, 32'hFFFF_FF80);

    // Other aligned and non-spanning variants
    issue(FNC_LBU, 32'h1, mk(32'h0000_0012, 0, 2, 0),
          mk(32'h0000_0012, 0, 2, 0));
    issue(FNC_LB, 32'h2, mk(32'hFFFF_FFFF, 0, 2, 0),
          mk(32'hFFFF_FFFF, 0, 2, 0));
    issue(FNC_LW, 32'h0, mk(32'h80FF_1234, 0, 2, 0),
          mk(32'h80FF_1234, 0, 2, 0));
    drain();

    // Half loads at offset 2
    mem[0] = 32'h8001_5678;
    issue(FNC_LHU, 32'h2, mk(32'h0000_8001, 0, 2, 0),
          mk(32'h0000_8001, 0, 2, 0));
    issue(FNC_LH, 32'h2, mk(32'hFFFF_8001, 0, 2, 0),
          mk(32'hFFFF_8001, 0, 2, 0));
    drain();

    // Spanning LW: two reads vs immediate error
    mem[1] = 32'hAABB_CCDD;
    mem[2] = 32'h1122_3344;
    a1q.delete();
    b1 = en1;
    b0 = en0;
    issue(FNC_LW, 32'h6, mk(32'h3344_AABB, 0, 3, 0),
          mk(32'h0, 1, 1, 0));
    drain();
    chk("lw_span mem_en_count", en1 - b1, 32'd2);
    chk("lw_span addr0", (a1q.size() > 0) ? a1q[0] : -1, 32'd1);
    chk("lw_span addr1", (a1q.size() > 1) ? a1q[1] : -1, 32'd2);
    chk("lw_span nomis mem_en", en0 - b0, 32'd0);

    // Spanning LHU at offset 3
    mem[0] = 32'h80FF_1234;
    issue(FNC_LHU, 32'h3, mk(32'h0000_DD80, 0, 3, 0),
          mk(32'h0, 1, 1, 0));
    drain();

    // Spanning LH at top of memory wraps to word 0
    mem[(1 << AW) - 1] = 32'hAB00_0000;
    mem[0] = 32'h80FF_12F4;
    a1q.delete();
    issue(FNC_LH, 32'h0000_FFFF, mk(32'hFFFF_F4AB, 0, 3, 0),
          mk(32'h0, 1, 1, 0));
    drain();
    chk("wrap addr0", (a1q.size() > 0) ? a1q[0] : -1,
        32'h3FFF);
    chk("wrap addr1", (a1q.size() > 1) ? a1q[1] : -1, 32'd0);

    // Illegal funct3, response held 5 cycles
    b1 = en1;
    issue(3'b011, 32'h0, mk(32'h0, 1, 1, 5),
          mk(32'h0, 1, 1, 5));
    drain();
    chk("illegal mem_en_count", en1 - b1, 32'd0);

    // Reset while the spanning load waits on its first read
    b1 = en1;
    issue(FNC_LW, 32'h5, mk(32'h0, 0, 3, 0),
          mk(32'h0, 1, 1, 0));
    #2;
    rst_n = 1'b0;
    #1;
    q1.delete();
    q0.delete();
    chk("midrst resp_valid", {31'b0, if1.resp_valid}, 32'd0);
    chk("midrst mem_en", {31'b0, if1.mem_en}, 32'd0);
    chk("midrst nomis resp_valid",
        {31'b0, if0.resp_valid}, 32'd0);
    chk("midrst resp_data", if0.resp_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst mem_en_count", en1 - b1, 32'd1);
    chk("postrst req_ready", {31'b0, if1.req_ready}, 32'd1);
    mem[4] = 32'hCAFE_F00D;
    issue(FNC_LW, 32'h10, mk(32'hCAFE_F00D, 0, 2, 0),
          mk(32'hCAFE_F00D, 0, 2, 0));
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
